neuron_input_loader: RTL and testbench

NEURON_INPUT_LOADER -- requirements
Module: neuron_input_loader

---
 rtl/neuron_pkg.sv | 25 ++
 rtl/loader_shreg.sv | 59 +++++
 rtl/neuron_input_loader.sv | 225 ++++++++++++++++++++++
 tb/tb_neuron_input_loader.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/neuron_pkg.sv
// -----------------------------------------------------------------------------
// neuron_pkg
// Shared types and constants for the neuron input loader: the loader FSM state
// enum, the byte width of the pin stream and the reset value of the negated
// threshold. Also provides a counter-width helper that stays legal when a
// frame is a single byte.
// -----------------------------------------------------------------------------
package neuron_pkg;

  localparam int unsigned BYTE_W         = 8;
  localparam int          MINUS_TETA_RST = -5;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    FILL_W  = 2'd1,
    FILL_X  = 2'd2,
    PRESENT = 2'd3
  } loader_state_t;

  // Width of a counter holding 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/loader_shreg.sv
// -----------------------------------------------------------------------------
// loader_shreg
// Byte-wide shift register that assembles an INPUTS-bit frame, plus the
// modulo-BYTES byte counter that marks the last byte of a frame.
//
// Ports
//   clk        in   rising-edge clock
//   reset      in   asynchronous active-high reset (clears register and count)
//   shift_en   in   shift data_in into the LSBs and advance the byte count
//   clear      in   drop the byte count back to zero (partial frame discard)
//   data_in    in   byte to shift in
//   q          out  assembled register contents; first byte ends in the MSBs
//   last_byte  out  the byte currently offered completes a frame
// -----------------------------------------------------------------------------
module loader_shreg
  import neuron_pkg::*;
#(
  parameter int unsigned INPUTS = 64
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              shift_en,
  input  logic              clear,
  input  logic [BYTE_W-1:0] data_in,
  output logic [INPUTS-1:0] q,
  output logic              last_byte
);

  localparam int unsigned BYTES = INPUTS / BYTE_W;
  localparam int unsigned CNT_W = cnt_width(BYTES);

  logic [INPUTS-1:0] r_shreg;
  logic [CNT_W-1:0]  r_count;
  logic [INPUTS-1:0] w_shifted;

  // Truncating the concatenation keeps the low INPUTS bits, i.e. the register
  // moved up one byte with the new byte in the LSBs (also valid for INPUTS=8).
  assign w_shifted = INPUTS'({r_shreg, data_in});
  assign last_byte = (r_count == CNT_W'(BYTES - 1));
  assign q         = r_shreg;

  // Shift register and byte counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_shreg <= '0;
      r_count <= '0;
    end else begin
      if (clear) begin
        r_count <= '0;
      end else if (shift_en) begin
        r_count <= last_byte ? '0 : r_count + CNT_W'(1);
      end
      if (shift_en && !clear) begin
        r_shreg <= w_shifted;
      end
    end
  end

endmodule

// File: rtl/neuron_input_loader.sv
// -----------------------------------------------------------------------------
// neuron_input_loader
// Collects a byte stream from the pins into either a weight vector (w) or an
// input spike vector (x) for the neuron. The first byte of a frame selects the
// frame type via mode_w. A completed input frame is presented with a
// valid/ready handshake; a completed weight frame is loaded silently.
//
// Build option
//   LOADER_THRESHOLD_CFG_EN  adds cfg_sel: an accepted byte in IDLE with
//                            cfg_sel high loads minus_teta and is not part of
//                            a frame. Without it minus_teta is fixed at -5.
//
// Parameters
//   N_STAGES        log2 of the synapse count, legal 3..6
//
// Ports
//   clk             in   rising-edge clock
//   reset           in   asynchronous active-high reset
//   data_in         in   byte stream from the pins
//   data_valid      in   data_in holds a byte
//   data_ready      out  loader accepts a byte this cycle
//   mode_w          in   frame type on the first byte: 1 weight, 0 input
//   flush           in   discard a partial frame
//   cfg_sel         in   (option only) byte in IDLE is a threshold write
//   x               out  presented input spike vector
//   w               out  loaded weight vector
//   frame_valid     out  x holds a complete, unconsumed input frame
//   frame_ready     in   neuron consumes x this cycle
//   weights_loaded  out  a weight frame has completed since reset
//   minus_teta      out  negated threshold for the neuron
// -----------------------------------------------------------------------------
module neuron_input_loader
  import neuron_pkg::*;
#(
  parameter  int unsigned N_STAGES         = 6,
  localparam int unsigned INPUTS           = 2 ** N_STAGES,
  localparam int unsigned BYTES            = INPUTS / 8,
  localparam int unsigned OUTPUT_PRECISION = N_STAGES + 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BYTE_W-1:0]           data_in,
  input  logic                        data_valid,
  output logic                        data_ready,
  input  logic                        mode_w,
  input  logic                        flush,
`ifdef LOADER_THRESHOLD_CFG_EN
  input  logic                        cfg_sel,
`endif
  output logic [INPUTS-1:0]           x,
  output logic [INPUTS-1:0]           w,
  output logic                        frame_valid,
  input  logic                        frame_ready,
  output logic                        weights_loaded,
  output logic [OUTPUT_PRECISION-1:0] minus_teta
);

  loader_state_t r_state;
  loader_state_t w_next_state;

  logic              w_accept;
  logic              w_frame_byte;
  logic              w_shift_en;
  logic              w_clear;
  logic              w_load_w;
  logic              w_load_x;
  logic              w_consume;
  logic              w_last_byte;
  logic [INPUTS-1:0] w_sh_q;
  logic [INPUTS-1:0] w_assembled;

  logic [INPUTS-1:0] r_x;
  logic [INPUTS-1:0] r_w;
  logic              r_frame_valid;
  logic              r_weights_loaded;

  // Ready is withheld while a frame is presented and throughout reset.
  assign data_ready = !reset && (r_state != PRESENT);
  assign w_accept   = data_valid && data_ready;

`ifdef LOADER_THRESHOLD_CFG_EN
  // Threshold writes only exist in IDLE; they never start a frame.
  logic w_cfg_load;
  assign w_cfg_load   = w_accept && cfg_sel && (r_state == IDLE);
  assign w_frame_byte = w_accept && !cfg_sel;
`else
  assign w_frame_byte = w_accept;
`endif

  // Value the frame holds once the current byte is shifted in; this is what
  // gets loaded into x or w on the completing byte.
  assign w_assembled = INPUTS'({w_sh_q, data_in});

  loader_shreg #(
    .INPUTS (INPUTS)
  ) u_shreg (
    .clk       (clk),
    .reset     (reset),
    .shift_en  (w_shift_en),
    .clear     (w_clear),
    .data_in   (data_in),
    .q         (w_sh_q),
    .last_byte (w_last_byte)
  );

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and datapath control.
  always_comb begin
    w_next_state = r_state;
    w_shift_en   = 1'b0;
    w_clear      = 1'b0;
    w_load_w     = 1'b0;
    w_load_x     = 1'b0;
    w_consume    = 1'b0;
    case (r_state)
      IDLE: begin
        // mode_w is sampled here only; with single-byte frames the first
        // byte also completes the frame.
        if (w_frame_byte) begin
          w_shift_en = 1'b1;
          if (mode_w) begin
            if (w_last_byte) begin
              w_load_w = 1'b1;
            end else begin
              w_next_state = FILL_W;
            end
          end else begin
            if (w_last_byte) begin
              w_load_x     = 1'b1;
              w_next_state = PRESENT;
            end else begin
              w_next_state = FILL_X;
            end
          end
        end
      end
      FILL_W: begin
        // Flush takes priority over a byte offered in the same cycle.
        if (flush) begin
          w_clear      = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          w_shift_en = 1'b1;
          if (w_last_byte) begin
            w_load_w     = 1'b1;
            w_next_state = IDLE;
          end
        end
      end
      FILL_X: begin
        if (flush) begin
          w_clear      = 1'b1;
          w_next_state = IDLE;
        end else if (w_accept) begin
          w_shift_en = 1'b1;
          if (w_last_byte) begin
            w_load_x     = 1'b1;
            w_next_state = PRESENT;
          end
        end
      end
      PRESENT: begin
        if (frame_ready) begin
          w_consume    = 1'b1;
          w_next_state = IDLE;
        end
      end
      default: begin
        w_next_state = IDLE;
      end
    endcase
  end

  // Output vectors and handshake flags.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_x              <= '0;
      r_w              <= '0;
      r_frame_valid    <= 1'b0;
      r_weights_loaded <= 1'b0;
    end else begin
      if (w_load_w) begin
        r_w              <= w_assembled;
        r_weights_loaded <= 1'b1;
      end
      if (w_load_x) begin
        r_x           <= w_assembled;
        r_frame_valid <= 1'b1;
      end else if (w_consume) begin
        r_frame_valid <= 1'b0;
      end
    end
  end

  assign x              = r_x;
  assign w              = r_w;
  assign frame_valid    = r_frame_valid;
  assign weights_loaded = r_weights_loaded;

`ifdef LOADER_THRESHOLD_CFG_EN
  logic [OUTPUT_PRECISION-1:0] r_minus_teta;

  // Programmable negated threshold; low bits of the config byte are taken.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_minus_teta <= OUTPUT_PRECISION'(MINUS_TETA_RST);
    end else if (w_cfg_load) begin
      r_minus_teta <= OUTPUT_PRECISION'(data_in);
    end
  end

  assign minus_teta = r_minus_teta;
`else
  assign minus_teta = OUTPUT_PRECISION'(MINUS_TETA_RST);
`endif

endmodule

// File: tb/tb_neuron_input_loader.sv
// -----------------------------------------------------------------------------
// tb_neuron_input_loader
// Directed, self-checking bench for neuron_input_loader at N_STAGES = 6
// (64-bit vectors, 8-byte frames). Inputs change 1 time unit after the rising
// edge; outputs are sampled at the same point.
// -----------------------------------------------------------------------------
module tb_neuron_input_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  data_in = 8'h00;
  logic        data_valid = 1'b0;
  logic        data_ready;
  logic        mode_w = 1'b0;
  logic        flush = 1'b0;
`ifdef LOADER_THRESHOLD_CFG_EN
  logic        cfg_sel = 1'b0;
`endif
  logic [63:0] x;
  logic [63:0] w;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic        weights_loaded;
  logic [7:0]  minus_teta;

  int n_checks = 0;
  int n_fail   = 0;

  neuron_input_loader #(
    .N_STAGES (6)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .data_in        (data_in),
    .data_valid     (data_valid),
    .data_ready     (data_ready),
    .mode_w         (mode_w),
    .flush          (flush),
`ifdef LOADER_THRESHOLD_CFG_EN
    .cfg_sel        (cfg_sel),
`endif
    .x              (x),
    .w              (w),
    .frame_valid    (frame_valid),
    .frame_ready    (frame_ready),
    .weights_loaded (weights_loaded),
    .minus_teta     (minus_teta)
  );

  always #5 clk = ~clk;

  // Offer one byte for exactly one rising edge.
  task automatic send_byte(input logic [7:0] b, input logic m);
    data_in    = b;
    mode_w     = m;
    data_valid = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
  endtask

  task automatic consume();
    frame_ready = 1'b1;
    @(posedge clk);
    #1;
    frame_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1;
    n_checks++; if (x !== 64'h0) begin n_fail++; $display("FAIL reset_x: got %h expected %h", x, 64'h0); end
    n_checks++; if (w !== 64'h0) begin n_fail++; $display("FAIL reset_w: got %h expected %h", w, 64'h0); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL reset_frame_valid: got %b expected 0", frame_valid); end
    n_checks++; if (weights_loaded !== 1'b0) begin n_fail++; $display("FAIL reset_weights_loaded: got %b expected 0", weights_loaded); end
    n_checks++; if (minus_teta !== 8'hFB) begin n_fail++; $display("FAIL reset_minus_teta: got %h expected fb", minus_teta); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL reset_data_ready: got %b expected 0", data_ready); end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL idle_data_ready: got %b expected 1", data_ready); end
  endtask

  task automatic test_weight_load();
    for (int i = 1; i <= 8; i++) begin
      send_byte(8'(i), 1'b1);
      n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL wload_frame_valid byte %0d: got %b expected 0", i, frame_valid); end
    end
    n_checks++; if (w !== 64'h0102030405060708) begin n_fail++; $display("FAIL wload_w: got %h expected %h", w, 64'h0102030405060708); end
    n_checks++; if (weights_loaded !== 1'b1) begin n_fail++; $display("FAIL wload_weights_loaded: got %b expected 1", weights_loaded); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL wload_data_ready: got %b expected 1", data_ready); end
    n_checks++; if (x !== 64'h0) begin n_fail++; $display("FAIL wload_x: got %h expected %h", x, 64'h0); end
  endtask

  // Input frame; mode_w toggles after the first byte and must be ignored.
  task automatic test_present();
    logic [63:0] exp_x;
    exp_x = 64'hFF00FF00FF00FF00;
    for (int i = 0; i < 8; i++) begin
      send_byte((i % 2 == 0) ? 8'hFF : 8'h00, (i == 0) ? 1'b0 : 1'(i % 2));
      if (i == 6) begin
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL present_early_valid: got %b expected 0", frame_valid); end
      end
    end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL present_frame_valid: got %b expected 1", frame_valid); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL present_data_ready: got %b expected 0", data_ready); end
    n_checks++; if (x !== exp_x) begin n_fail++; $display("FAIL present_x: got %h expected %h", x, exp_x); end
    n_checks++; if (w !== 64'h0102030405060708) begin n_fail++; $display("FAIL present_w_kept: got %h expected %h", w, 64'h0102030405060708); end
    // Bytes and a flush offered while presenting must have no effect.
    data_in    = 8'hAA;
    data_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    data_valid = 1'b0;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    n_checks++; if (x !== exp_x) begin n_fail++; $display("FAIL present_x_stable: got %h expected %h", x, exp_x); end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL present_valid_held: got %b expected 1", frame_valid); end
    consume();
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL consume_frame_valid: got %b expected 0", frame_valid); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL consume_data_ready: got %b expected 1", data_ready); end
    n_checks++; if (x !== exp_x) begin n_fail++; $display("FAIL consume_x_retained: got %h expected %h", x, exp_x); end
  endtask

  task automatic test_flush();
    logic [63:0] old_x;
    logic [63:0] exp_x;
    old_x = 64'hFF00FF00FF00FF00;
    exp_x = 64'h2122232425262728;
    for (int i = 0; i < 5; i++) send_byte(8'(8'h11 + i), 1'b0);
    data_in    = 8'h16;
    data_valid = 1'b1;
    flush      = 1'b1;
    @(posedge clk);
    #1;
    data_valid = 1'b0;
    flush      = 1'b0;
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_frame_valid: got %b expected 0", frame_valid); end
    n_checks++; if (x !== old_x) begin n_fail++; $display("FAIL flush_x_kept: got %h expected %h", x, old_x); end
    for (int i = 0; i < 8; i++) begin
      send_byte(8'(8'h21 + i), 1'b0);
      if (i == 6) begin
        n_checks++; if (x !== old_x) begin n_fail++; $display("FAIL flush_old_x_until_done: got %h expected %h", x, old_x); end
        n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL flush_early_valid: got %b expected 0", frame_valid); end
      end
    end
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL flush_next_valid: got %b expected 1", frame_valid); end
    n_checks++; if (x !== exp_x) begin n_fail++; $display("FAIL flush_next_x: got %h expected %h", x, exp_x); end
    n_checks++; if (weights_loaded !== 1'b1) begin n_fail++; $display("FAIL flush_weights_loaded: got %b expected 1", weights_loaded); end
    consume();
  endtask

  task automatic test_reset_mid_frame();
    for (int i = 0; i < 4; i++) send_byte(8'(8'hA1 + i), 1'b1);
    reset = 1'b1;
    #1;
    n_checks++; if (w !== 64'h0) begin n_fail++; $display("FAIL midrst_w: got %h expected %h", w, 64'h0); end
    n_checks++; if (x !== 64'h0) begin n_fail++; $display("FAIL midrst_x: got %h expected %h", x, 64'h0); end
    n_checks++; if (weights_loaded !== 1'b0) begin n_fail++; $display("FAIL midrst_weights_loaded: got %b expected 0", weights_loaded); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL midrst_frame_valid: got %b expected 0", frame_valid); end
    n_checks++; if (minus_teta !== 8'hFB) begin n_fail++; $display("FAIL midrst_minus_teta: got %h expected fb", minus_teta); end
    n_checks++; if (data_ready !== 1'b0) begin n_fail++; $display("FAIL midrst_data_ready: got %b expected 0", data_ready); end
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Input frame before any weights, then a fresh weight frame from count 0.
  task automatic test_no_weights();
    for (int i = 0; i < 8; i++) send_byte(8'(8'h31 + i), 1'b0);
    n_checks++; if (frame_valid !== 1'b1) begin n_fail++; $display("FAIL nowt_frame_valid: got %b expected 1", frame_valid); end
    n_checks++; if (x !== 64'h3132333435363738) begin n_fail++; $display("FAIL nowt_x: got %h expected %h", x, 64'h3132333435363738); end
    n_checks++; if (w !== 64'h0) begin n_fail++; $display("FAIL nowt_w: got %h expected %h", w, 64'h0); end
    n_checks++; if (weights_loaded !== 1'b0) begin n_fail++; $display("FAIL nowt_weights_loaded: got %b expected 0", weights_loaded); end
    consume();
    for (int i = 0; i < 8; i++) send_byte(8'(8'hB1 + i), 1'b1);
    n_checks++; if (w !== 64'hB1B2B3B4B5B6B7B8) begin n_fail++; $display("FAIL reload_w: got %h expected %h", w, 64'hB1B2B3B4B5B6B7B8); end
    n_checks++; if (weights_loaded !== 1'b1) begin n_fail++; $display("FAIL reload_weights_loaded: got %b expected 1", weights_loaded); end
    n_checks++; if (x !== 64'h3132333435363738) begin n_fail++; $display("FAIL reload_x_kept: got %h expected %h", x, 64'h3132333435363738); end
`ifndef LOADER_THRESHOLD_CFG_EN
    n_checks++; if (minus_teta !== 8'hFB) begin n_fail++; $display("FAIL fixed_minus_teta: got %h expected fb", minus_teta); end
`endif
  endtask

`ifdef LOADER_THRESHOLD_CFG_EN
  task automatic test_cfg();
    cfg_sel = 1'b1;
    send_byte(8'hF0, 1'b0);
    cfg_sel = 1'b0;
    n_checks++; if (minus_teta !== 8'hF0) begin n_fail++; $display("FAIL cfg_minus_teta: got %h expected f0", minus_teta); end
    n_checks++; if (data_ready !== 1'b1) begin n_fail++; $display("FAIL cfg_stays_idle: got %b expected 1", data_ready); end
    n_checks++; if (frame_valid !== 1'b0) begin n_fail++; $display("FAIL cfg_frame_valid: got %b expected 0", frame_valid); end
    for (int i = 0; i < 8; i++) send_byte(8'(8'hC1 + i), 1'b1);
    n_checks++; if (w !== 64'hC1C2C3C4C5C6C7C8) begin n_fail++; $display("FAIL cfg_w: got %h expected %h", w, 64'hC1C2C3C4C5C6C7C8); end
    n_checks++; if (minus_teta !== 8'hF0) begin n_fail++; $display("FAIL cfg_minus_teta_kept: got %h expected f0", minus_teta); end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "watchdog timeout");
  end

  initial begin
    test_reset();
    test_weight_load();
    test_present();
    test_flush();
    test_reset_mid_frame();
    test_no_weights();
`ifdef LOADER_THRESHOLD_CFG_EN
    test_cfg();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
